// File: rtl/testbus_capture.sv
// Test bus capture: once armed, waits for a masked trigger, then logs {timestamp, bus} on every bus change.
// FSM: IDLE (no writes) -> ARMED (wait for trigger) -> CAPTURE (log changes) -> DONE (hold until re-armed).
module testbus_capture #(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16
) (
    input  logic                      i_CLK,
    input  logic                      i_RESET_n,
    input  logic [7:0]                iv_TEST_BUS,
    input  logic                      i_ARM,
    input  logic [7:0]                iv_TRIG_VALUE,
    input  logic [7:0]                iv_TRIG_MASK,
    output logic [8+TS_WIDTH-1:0]     ov_RD_DATA,
    output logic                      o_RD_VALID,
    input  logic                      i_RD_READY,
    output logic [$clog2(DEPTH):0]    ov_LEVEL,
    output logic                      o_FULL,
    output logic                      o_OVERFLOW,
    output logic                      o_TRIGGERED,
    output logic                      o_LED
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = 8 + TS_WIDTH;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t              state;
    logic [TS_WIDTH-1:0] ts_cnt;
    logic [TS_WIDTH-1:0] ts_q;
    logic [7:0]          s_q;
    logic [7:0]          p_q;
    logic [LW-1:0]       cap_cnt;
    logic [DW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level_next;
    logic [DW-1:0]       wr_data;
    logic                trig_hit;
    logic                wr_req;
    logic                pop;
    logic                push;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            ts_cnt <= '0;
            ts_q   <= '0;
            s_q    <= '0;
            p_q    <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
            ts_q   <= ts_cnt;
            s_q    <= iv_TEST_BUS;
            p_q    <= s_q;
        end
    end

    assign trig_hit = ((s_q ^ iv_TRIG_VALUE) & iv_TRIG_MASK) == 8'h00;
    assign wr_req   = ((state == ARMED) && trig_hit) || ((state == CAPTURE) && (s_q != p_q));
    assign pop      = o_RD_VALID && i_RD_READY;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
    assign push     = wr_req && (!o_FULL || pop);
    assign wr_data  = {ts_q, s_q};

    always_comb begin
        level_next = ov_LEVEL;
        if (push && !pop) begin
            level_next = ov_LEVEL + LW'(1);
        end else if (pop && !push) begin
            level_next = ov_LEVEL - LW'(1);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ov_LEVEL   <= '0;
            o_FULL     <= 1'b0;
            o_RD_VALID <= 1'b0;
            ov_RD_DATA <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            ov_LEVEL   <= level_next;
            o_FULL     <= (level_next == DEPTH_L);
            o_RD_VALID <= (level_next != '0);
            // Head register: bypass the write when the FIFO is (or is about to be) empty.
            if (push && ((ov_LEVEL == '0) || (pop && (ov_LEVEL == LW'(1))))) begin
                ov_RD_DATA <= wr_data;
            end else if (pop && (ov_LEVEL > LW'(1))) begin
                ov_RD_DATA <= mem[rd_ptr + AW'(1)];
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state       <= IDLE;
            cap_cnt     <= '0;
            o_OVERFLOW  <= 1'b0;
            o_TRIGGERED <= 1'b0;
            o_LED       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_ARM) begin
                        state       <= ARMED;
                        cap_cnt     <= '0;
                        o_OVERFLOW  <= 1'b0;
                        o_TRIGGERED <= 1'b0;
                    end
                end
                ARMED: begin
                    if (trig_hit) begin
                        state       <= CAPTURE;
                        cap_cnt     <= LW'(1);
                        o_TRIGGERED <= 1'b1;
                        o_LED       <= 1'b1;
                        if (!push) begin
                            o_OVERFLOW <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (wr_req) begin
                        cap_cnt <= cap_cnt + LW'(1);
                        if (!push) begin
                            o_OVERFLOW <= 1'b1;
                        end
                        if ((cap_cnt + LW'(1)) == DEPTH_L) begin
                            state <= DONE;
                            o_LED <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    o_LED <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_testbus_capture.sv
// Directed bench for testbus_capture: expected entries are queued when the bus is driven and compared as the host pops them.
module tb_testbus_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  bus;
    logic        arm;
    logic [7:0]  trig_value;
    logic [7:0]  trig_mask;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  level;
    logic        full;
    logic        overflow;
    logic        triggered;
    logic        led;

    int          passed = 0;
    int          total  = 0;
    logic [3:0]  tcnt;
    logic [11:0] q[$];
    logic [31:0] sb_exp;

    testbus_capture #(.DEPTH(16), .TS_WIDTH(4)) dut (
        .i_CLK        (clk),
        .i_RESET_n    (rst_n),
        .iv_TEST_BUS  (bus),
        .i_ARM        (arm),
        .iv_TRIG_VALUE(trig_value),
        .iv_TRIG_MASK (trig_mask),
        .ov_RD_DATA   (rd_data),
        .o_RD_VALID   (rd_valid),
        .i_RD_READY   (rd_ready),
        .ov_LEVEL     (level),
        .o_FULL       (full),
        .o_OVERFLOW   (overflow),
        .o_TRIGGERED  (triggered),
        .o_LED        (led)
    );

    always #5 clk = ~clk;

    // Timestamp reference: edges seen since reset release, modulo 16.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= 4'd0;
        else        tcnt <= tcnt + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            if (q.size() > 0) sb_exp = 32'(q.pop_front());
            else              sb_exp = 'x;
            chk("sb_entry", 32'(rd_data), sb_exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        arm      = 1'b0;
        rd_ready = 1'b0;
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        rd_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!rd_valid) break;
        end
        rd_ready = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_sb_left"}, 32'(q.size()), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        bus        = 8'h00;
        arm        = 1'b0;
        trig_value = 8'h00;
        trig_mask  = 8'h00;
        rd_ready   = 1'b0;
        apply_reset();

        chk("rst_rd_data",   32'(rd_data),   32'd0);
        chk("rst_valid",     32'(rd_valid),  32'd0);
        chk("rst_level",     32'(level),     32'd0);
        chk("rst_full",      32'(full),      32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        chk("rst_led",       32'(led),       32'd0);

        // Trigger match on the low nibble
        trig_mask  = 8'h0F;
        trig_value = 8'h05;
        bus = 8'h10; arm = 1'b1;
        tick();
        arm = 1'b0;
        bus = 8'h25; q.push_back({tcnt, bus});
        tick();
        chk("trig_valid_1cyc", 32'(rd_valid), 32'd0);
        chk("trig_trig_1cyc",  32'(triggered), 32'd0);
        tick();
        chk("trig_valid_2cyc", 32'(rd_valid), 32'd1);
        chk("trig_triggered",  32'(triggered), 32'd1);
        chk("trig_led",        32'(led), 32'd1);
        bus = 8'h26; q.push_back({tcnt, bus});
        tick();
        tick();
        chk("trig_level", 32'(level), 32'd2);
        drain("trig_drain");

        // Full capture with the reader stalled
        apply_reset();
        trig_mask = 8'h00;
        trig_value = 8'h00;
        for (int i = 0; i < 20; i++) begin
            bus = 8'h40 + 8'(i);
            if (i == 0) arm = 1'b1;
            if (i < 16) q.push_back({tcnt, bus});
            tick();
            arm = 1'b0;
            if (i == 15) begin
                chk("full_level15", 32'(level), 32'd15);
                chk("full_led15",   32'(led),   32'd1);
            end
            if (i == 16) begin
                chk("full_level16", 32'(level), 32'd16);
                chk("full_done",    32'(led),   32'd0);
            end
        end
        chk("full_full",     32'(full),     32'd1);
        chk("full_overflow", 32'(overflow), 32'd0);
        chk("full_level",    32'(level),    32'd16);

        // Pop two to leave 14 entries, then overflow
        rd_ready = 1'b1;
        tick();
        tick();
        rd_ready = 1'b0;
        chk("prefill_level", 32'(level), 32'd14);
        chk("prefill_full",  32'(full),  32'd0);
        for (int i = 0; i < 5; i++) begin
            bus = (i % 2 == 1) ? 8'h55 : 8'hAA;
            if (i == 0) arm = 1'b1;
            if (i < 2) q.push_back({tcnt, bus});
            tick();
            arm = 1'b0;
        end
        tick();
        tick();
        chk("ovf_overflow", 32'(overflow), 32'd1);
        chk("ovf_level",    32'(level),    32'd16);
        chk("ovf_full",     32'(full),     32'd1);
        chk("ovf_led",      32'(led),      32'd1);

        // Push and pop together while full
        bus = 8'h33; q.push_back({tcnt, bus});
        tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("pp_level", 32'(level), 32'd16);
        chk("pp_full",  32'(full),  32'd1);

        // Dropped changes finish the capture, then re-arm clears the flags
        for (int i = 0; i < 10; i++) begin
            bus = (i % 2 == 1) ? 8'h33 : 8'hCC;
            tick();
        end
        tick();
        tick();
        chk("ovf_done_led", 32'(led),      32'd0);
        chk("ovf_done_ovf", 32'(overflow), 32'd1);
        trig_mask  = 8'hFF;
        trig_value = 8'h00;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("rearm_overflow",  32'(overflow),  32'd0);
        chk("rearm_triggered", 32'(triggered), 32'd0);
        chk("rearm_level",     32'(level),     32'd16);
        drain("ovf_drain");

        // Timestamp wrap with a change every 5 cycles, reader streaming
        apply_reset();
        trig_mask  = 8'h00;
        trig_value = 8'h00;
        rd_ready   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i % 5 == 0) begin
                bus = 8'(i / 5 + 1);
                q.push_back({tcnt, bus});
            end
            if (i == 0) arm = 1'b1;
            tick();
            arm = 1'b0;
        end
        tick();
        tick();
        tick();
        chk("wrap_valid",   32'(rd_valid), 32'd0);
        chk("wrap_sb_left", 32'(q.size()), 32'd0);
        rd_ready = 1'b0;

        // Asynchronous reset in the middle of a capture
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            bus = 8'h80 + 8'(i);
            if (i == 0) arm = 1'b1;
            tick();
            arm = 1'b0;
        end
        tick();
        chk("mid_level", 32'(level), 32'd7);
        chk("mid_led",   32'(led),   32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_valid",     32'(rd_valid),  32'd0);
        chk("arst_level",     32'(level),     32'd0);
        chk("arst_led",       32'(led),       32'd0);
        chk("arst_triggered", 32'(triggered), 32'd0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus = 8'h90 + 8'(i);
            tick();
        end
        tick();
        chk("idle_no_write", 32'(rd_valid), 32'd0);
        chk("idle_led",      32'(led),      32'd0);
        bus = 8'hA7; arm = 1'b1; q.push_back({tcnt, bus});
        tick();
        arm = 1'b0;
        tick();
        tick();
        chk("post_arm_valid", 32'(rd_valid), 32'd1);
        drain("post_arm_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/testbus_capture.md
# testbus_capture

Capture block for the 8-bit FPGA test bus. It sits at the receiving end of the test bus, on a board-level monitor FPGA or inside the simulation bench top. Once armed, it waits for a masked trigger pattern, then records every bus value change with a timestamp into an internal FIFO. A host drains the FIFO through a valid/ready read port. The LED output shows capture activity.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..256; also the capture length in entries.
- TS_WIDTH, 16, timestamp counter width.

Ports:
- i_CLK  in  1  system clock; all logic on the rising edge.
- i_RESET_n  in  1  reset, asynchronous assert, active-low.
- iv_TEST_BUS  in  8  observed test bus, synchronous to i_CLK.
- i_ARM  in  1  single-cycle arm request.
- iv_TRIG_VALUE  in  8  trigger compare value.
- iv_TRIG_MASK  in  8  trigger compare mask; 1 = bit compared.
- ov_RD_DATA  out  8+TS_WIDTH  FIFO head, {timestamp, bus value}.
- o_RD_VALID  out  1  FIFO not empty.
- i_RD_READY  in  1  host accepts head.
- ov_LEVEL  out  log2(DEPTH)+1  FIFO occupancy.
- o_FULL  out  1  occupancy == DEPTH.
- o_OVERFLOW  out  1  sticky: at least one change was dropped.
- o_TRIGGERED  out  1  trigger seen since last arm.
- o_LED  out  1  high while state is CAPTURE.

## Operation
- Input stage: iv_TEST_BUS is registered into s_q, and the timestamp counter value is registered alongside it as ts_q. A second register, p_q, holds the previous s_q.
- Timestamp counter: resets to 0, increments every cycle, wraps modulo 2^TS_WIDTH with no flag.
- States:
  - IDLE: no writes.
  - ARMED: wait for the trigger.
  - CAPTURE: record changes.
  - DONE: hold.
- Transitions:
  - Reset -> IDLE.
  - i_ARM in IDLE or DONE -> ARMED. On this transition, o_OVERFLOW, o_TRIGGERED and the capture count are cleared. FIFO contents are kept.
  - i_ARM in ARMED or CAPTURE is ignored.
  - ARMED: if (s_q & mask) == (value & mask), write {ts_q, s_q}, set o_TRIGGERED, set capture count to 1, go to CAPTURE. With mask 0x00 this fires on the first ARMED cycle.
  - CAPTURE: if s_q != p_q, a write is attempted. An attempt when the FIFO cannot accept is dropped and sets o_OVERFLOW; it still counts toward the capture count.
  - CAPTURE: when the capture count reaches DEPTH, go to DONE.
  - DONE: hold until i_ARM.
- Write rules:
  - Write accepted when !o_FULL, or when a pop happens in the same cycle.
  - A simultaneous push and pop leaves ov_LEVEL unchanged.
  - Write and read pointers wrap at DEPTH.
- Read port:
  - First-word fall-through.
  - Pop occurs when o_RD_VALID && i_RD_READY.
  - When empty, ov_RD_DATA holds its last value; at reset it is 0.
  - i_RD_READY while empty is ignored.
- Reset mid-capture: the FIFO empties, state returns to IDLE, and the counter returns to 0. No partial entries survive.
- Reset values:
  - ov_RD_DATA = 0, o_RD_VALID = 0, ov_LEVEL = 0.
  - o_FULL = 0, o_OVERFLOW = 0, o_TRIGGERED = 0, o_LED = 0.

## Timing
- A bus value present before edge k is in s_q after edge k. The entry for it is written at edge k+1. o_RD_VALID rises after edge k+1, so latency from bus to valid is 2 cycles.
- Entry timestamp = counter value sampled at edge k.
- A single-cycle bus glitch (A, B, A) yields two entries, B and A, with consecutive timestamps.
- o_TRIGGERED and the CAPTURE state (o_LED high) are asserted after the trigger write edge.
- o_FULL, ov_LEVEL and o_OVERFLOW are registered and update on the same edge as the push or pop that changes them.
- A pop at edge m presents the next entry on ov_RD_DATA after edge m. Sustained throughput is one entry per cycle.
- i_ARM sampled at edge j puts the state in ARMED after edge j. The trigger compare uses s_q from the cycle after edge j.

## Test plan
- Trigger match: mask 0x0F, value 0x05. Arm, then drive bus 0x10, 0x25, 0x25, 0x26.
  - Required: first entry data 0x25, then 0x26.
  - o_TRIGGERED goes high; o_RD_VALID goes high 2 cycles after 0x25 appears on the bus.
- Full capture, reader stalled: DEPTH=16, mask 0x00, i_RD_READY=0. Bus increments every cycle for 20 cycles.
  - Required: 16 entries; o_FULL=1; state DONE after the 16th attempt; o_OVERFLOW=0.
  - Timestamps are consecutive.
- Overflow: mask 0x00, i_RD_READY=0. Pre-fill the FIFO with 14 entries from an earlier capture, then arm and toggle the bus 5 times.
  - Required: 2 entries accepted, 3 dropped; o_OVERFLOW=1.
  - o_OVERFLOW clears on the next arm.
- Simultaneous push and pop at full: FIFO full, i_RD_READY=1 during a bus change.
  - Required: ov_LEVEL stays 16 and o_FULL stays 1.
  - Popped data is the oldest entry; the new entry lands at the tail.
- Timestamp wrap: TS_WIDTH=4, bus change every 5 cycles.
  - Required: timestamps step by 5 modulo 16, e.g. 14 -> 3.
- Async reset mid-CAPTURE: assert i_RESET_n=0 for half a cycle with 7 entries held.
  - Required: immediately o_RD_VALID=0, ov_LEVEL=0, o_LED=0, o_TRIGGERED=0.
  - After release: state IDLE; the next write needs i_ARM.
